// File: rtl/vga_pkg.sv
// Shared display/game constants and the paddle mode encoding.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_MULTI  = 2'd2
  } mode_t;

  localparam int unsigned SCREEN_H_DEF = 768;
  localparam int unsigned PADDLE_H_DEF = 96;
  localparam int unsigned MAX_STEP_DEF = 8;

  // Unsigned upper clamp on raw 12-bit coordinates.
  function automatic logic [11:0] clamp_u12(input logic [11:0] v, input logic [11:0] hi);
    return (v > hi) ? hi : v;
  endfunction

endpackage

// File: rtl/paddle_slew.sv
// One paddle: clamps its target to the playfield, limits the per-frame
// move to MAX_STEP and holds the registered top position.
module paddle_slew
  import vga_pkg::*;
#(
  parameter int unsigned POS_W    = 10,
  parameter int unsigned PMAX     = 672,
  parameter int unsigned CENTER   = 336,
  parameter int unsigned MAX_STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd,
  input  logic [11:0]      target,
  output logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] pos_nxt
);

  logic [POS_W-1:0]        tgt;
  logic signed [POS_W+1:0] diff;
  logic [POS_W+1:0]        mag;

  // Clamp target, then move fully or by MAX_STEP toward it on an update.
  always_comb begin
    tgt     = POS_W'(clamp_u12(target, 12'(PMAX)));
    diff    = $signed({2'b00, tgt}) - $signed({2'b00, pos});
    mag     = diff[POS_W+1] ? $unsigned(-diff) : $unsigned(diff);
    pos_nxt = pos;
    if (upd) begin
      if (mag <= (POS_W+2)'(MAX_STEP))
        pos_nxt = tgt;
      else if (diff[POS_W+1])
        pos_nxt = pos - POS_W'(MAX_STEP);
      else
        pos_nxt = pos + POS_W'(MAX_STEP);
    end
  end

  // Position register, parked at screen centre on reset.
  always_ff @(posedge clk) begin
    if (rst) pos <= POS_W'(CENTER);
    else     pos <= pos_nxt;
  end

endmodule

// File: rtl/paddle_pos_ctl.sv
// Paddle position controller: game-mode FSM, per-paddle target selection
// and frame-rate slew of every paddle. Optional CPU ball tracking for
// non-local paddles in single-player mode is built when PADDLE_AI_EN is
// defined.
module paddle_pos_ctl
  import vga_pkg::*;
#(
  parameter int unsigned N_PADDLES = 2,
  parameter int unsigned POS_W     = 10,
  parameter int unsigned SCREEN_H  = SCREEN_H_DEF,
  parameter int unsigned PADDLE_H  = PADDLE_H_DEF,
  parameter int unsigned MAX_STEP  = MAX_STEP_DEF
) (
  input  logic                           clk65MHz,
  input  logic                           rst,
  input  logic                           frame_tick,
  input  logic                           screen_idle,
  input  logic                           screen_single,
  input  logic                           screen_multi,
  input  logic [11:0]                    mouse_ypos,
  input  logic [POS_W-1:0]               remote_ypos,
  input  logic [11:0]                    ball_ypos,
  input  logic [$clog2(N_PADDLES)-1:0]   local_sel,
  output logic [N_PADDLES*POS_W-1:0]     paddle_ypos,
  output logic [POS_W-1:0]               output_pos,
  output logic                           pos_valid
);

  localparam int unsigned SEL_W  = $clog2(N_PADDLES);
  localparam int unsigned CENTER = (SCREEN_H - PADDLE_H) / 2;
  localparam int unsigned PMAX   = SCREEN_H - PADDLE_H;
  localparam int unsigned HALF_H = PADDLE_H / 2;

  logic             tick_d;
  logic             tick_rise;
  mode_t            state;
  mode_t            state_nxt;
  logic [11:0]      remote_12;
  logic [11:0]      cpu_target;
  logic [11:0]      target  [N_PADDLES];
  logic [POS_W-1:0] pos_q   [N_PADDLES];
  logic [POS_W-1:0] pos_nxt [N_PADDLES];
  logic [POS_W-1:0] local_nxt;

  assign remote_12 = 12'(remote_ypos);

`ifdef PADDLE_AI_EN
  // CPU paddle centres on the ball, floored at the top of the screen.
  assign cpu_target = (ball_ypos >= 12'(HALF_H)) ? ball_ypos - 12'(HALF_H) : '0;
`else
  logic unused_ball;
  assign unused_ball = ^ball_ypos;
  assign cpu_target  = 12'(CENTER);
`endif

  // Rising-edge detector so a stretched frame_tick yields one update.
  always_ff @(posedge clk65MHz) begin
    if (rst) tick_d <= 1'b0;
    else     tick_d <= frame_tick;
  end

  assign tick_rise = frame_tick & ~tick_d;

  // Mode state register.
  always_ff @(posedge clk65MHz) begin
    if (rst) state <= MODE_IDLE;
    else     state <= state_nxt;
  end

  // Next mode on a tick: idle beats single beats multi; no request holds.
  always_comb begin
    state_nxt = state;
    if (tick_rise) begin
      if (screen_idle)        state_nxt = MODE_IDLE;
      else if (screen_single) state_nxt = MODE_SINGLE;
      else if (screen_multi)  state_nxt = MODE_MULTI;
    end
  end

  // Target mux driven from the next mode so a tick's update already
  // reflects the mode chosen on that same tick.
  always_comb begin
    for (int unsigned i = 0; i < N_PADDLES; i++) begin
      target[i] = 12'(CENTER);
      case (state_nxt)
        MODE_SINGLE: target[i] = (local_sel == SEL_W'(i)) ? mouse_ypos : cpu_target;
        MODE_MULTI:  target[i] = (local_sel == SEL_W'(i)) ? mouse_ypos : remote_12;
        default:     target[i] = 12'(CENTER);
      endcase
    end
  end

  for (genvar g = 0; g < N_PADDLES; g++) begin : g_paddle
    paddle_slew #(
      .POS_W    (POS_W),
      .PMAX     (PMAX),
      .CENTER   (CENTER),
      .MAX_STEP (MAX_STEP)
    ) u_slew (
      .clk     (clk65MHz),
      .rst     (rst),
      .upd     (tick_rise),
      .target  (target[g]),
      .pos     (pos_q[g]),
      .pos_nxt (pos_nxt[g])
    );
    assign paddle_ypos[g*POS_W +: POS_W] = pos_q[g];
  end

  // Select the local paddle's upcoming position for the link register.
  always_comb begin
    local_nxt = pos_nxt[0];
    for (int unsigned i = 0; i < N_PADDLES; i++)
      if (local_sel == SEL_W'(i)) local_nxt = pos_nxt[i];
  end

  // Commit strobe and link position, both aligned with the paddle registers.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      pos_valid  <= 1'b0;
      output_pos <= POS_W'(CENTER);
    end else begin
      pos_valid <= tick_rise;
      if (tick_rise) output_pos <= local_nxt;
    end
  end

endmodule

// File: tb/tb_paddle_pos_ctl.sv
// Directed and randomized check of paddle_pos_ctl against an arithmetic
// model of the paddle rules (default parameters, 2 paddles).
module tb_paddle_pos_ctl;
  import vga_pkg::*;

  localparam int NP = 2;
  localparam int PW = 10;
  localparam int CENTER = 336;
  localparam int PMAX = 672;
  localparam int STEP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_tick = 1'b0;
  logic          screen_idle = 1'b0, screen_single = 1'b0, screen_multi = 1'b0;
  logic [11:0]   mouse_ypos = '0;
  logic [PW-1:0] remote_ypos = '0;
  logic [11:0]   ball_ypos = 12'd384;
  logic [0:0]    local_sel = '0;
  logic [NP*PW-1:0] paddle_ypos;
  logic [PW-1:0] output_pos;
  logic          pos_valid;

  int n_cmp = 0;
  int n_bad = 0;

  int    mp [NP];
  int    mout;
  mode_t mmode;

  always #5 clk = ~clk;

  paddle_pos_ctl dut (
    .clk65MHz      (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .screen_idle   (screen_idle),
    .screen_single (screen_single),
    .screen_multi  (screen_multi),
    .mouse_ypos    (mouse_ypos),
    .remote_ypos   (remote_ypos),
    .ball_ypos     (ball_ypos),
    .local_sel     (local_sel),
    .paddle_ypos   (paddle_ypos),
    .output_pos    (output_pos),
    .pos_valid     (pos_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampv(input int v);
    return (v > PMAX) ? PMAX : v;
  endfunction

  function automatic int stepv(input int p, input int t);
    int d = t - p;
    if (d >= -STEP && d <= STEP) return t;
    return (d > 0) ? p + STEP : p - STEP;
  endfunction

  function automatic int paddle(input int i);
    logic [PW-1:0] v;
    v = paddle_ypos[i*PW +: PW];
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) mp[i] = CENTER;
    mout  = CENTER;
    mmode = MODE_IDLE;
  endtask

  task automatic model_tick();
    int t;
    if (screen_idle)        mmode = MODE_IDLE;
    else if (screen_single) mmode = MODE_SINGLE;
    else if (screen_multi)  mmode = MODE_MULTI;
    for (int i = 0; i < NP; i++) begin
      if (mmode == MODE_IDLE) t = CENTER;
      else if (i == int'(local_sel)) t = clampv(int'(mouse_ypos));
      else if (mmode == MODE_MULTI) t = clampv(int'(remote_ypos));
      else begin
`ifdef PADDLE_AI_EN
        t = int'(ball_ypos) - 48;
        if (t < 0) t = 0;
        t = clampv(t);
`else
        t = CENTER;
`endif
      end
      mp[i] = stepv(mp[i], t);
    end
    mout = mp[int'(local_sel)];
  endtask

  task automatic check_all(input logic exp_pv);
    for (int i = 0; i < NP; i++) begin
      check($sformatf("paddle%0d", i), 32'(paddle(i)), 32'(mp[i]));
      check($sformatf("paddle%0d_in_range", i), 32'(paddle(i) <= PMAX), 32'd1);
    end
    check("output_pos", 32'(output_pos), 32'(mout));
    check("pos_valid", 32'(pos_valid), 32'(exp_pv));
    check("mode", 32'(dut.state), 32'(mmode));
  endtask

  // One single-cycle tick, then one quiet cycle.
  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(posedge clk); #1;
    model_tick();
    check_all(1'b1);
    @(negedge clk); frame_tick = 1'b0;
    @(posedge clk); #1;
    check("pos_valid_drop", 32'(pos_valid), 32'd0);
  endtask

  task automatic do_reset(input logic with_tick);
    @(negedge clk); rst = 1'b1; frame_tick = with_tick;
    @(posedge clk); #1;
    model_reset();
    check_all(1'b0);
    @(negedge clk); rst = 1'b0; frame_tick = 1'b0;
    @(posedge clk); #1;
    check_all(1'b0);
  endtask

  task automatic set_mode(input logic i, input logic s, input logic m);
    @(negedge clk);
    screen_idle = i; screen_single = s; screen_multi = m;
  endtask

  initial begin
    // Reset state
    do_reset(1'b0);
    check("rst_p0", 32'(paddle(0)), 32'd336);
    check("rst_p1", 32'(paddle(1)), 32'd336);
    check("rst_out", 32'(output_pos), 32'd336);

    // Single player, mouse at 100
    set_mode(1'b0, 1'b1, 1'b0);
    local_sel = 1'b0; mouse_ypos = 12'd100; ball_ypos = 12'd384;
    tick();
    check("single_first_step", 32'(paddle(0)), 32'd328);
    for (int k = 0; k < 29; k++) tick();
    check("single_settled", 32'(paddle(0)), 32'd100);

    // Mouse far below the playfield: clamp at PMAX
    mouse_ypos = 12'd4000;
    for (int k = 0; k < 75; k++) tick();
    check("clamp_pmax", 32'(paddle(0)), 32'd672);

    // CPU paddle toward ball at 600
    do_reset(1'b0);
    set_mode(1'b0, 1'b1, 1'b0);
    ball_ypos = 12'd600;
    tick();
`ifdef PADDLE_AI_EN
    check("cpu_paddle", 32'(paddle(1)), 32'd344);
`else
    check("cpu_paddle", 32'(paddle(1)), 32'd336);
`endif

    // Multi player, remote small move lands directly
    do_reset(1'b0);
    set_mode(1'b0, 1'b0, 1'b1);
    remote_ypos = 10'd340;
    tick();
    check("multi_remote", 32'(paddle(1)), 32'd340);

    // Idle beats single; no request holds the mode
    set_mode(1'b1, 1'b1, 1'b0);
    tick();
    check("prio_idle", 32'(dut.state), 32'(MODE_IDLE));
    set_mode(1'b0, 1'b1, 1'b0);
    tick();
    set_mode(1'b0, 1'b0, 1'b0);
    tick();
    check("mode_held", 32'(dut.state), 32'(MODE_SINGLE));

    // local_sel change waits for the next tick
    mouse_ypos = 12'd0; remote_ypos = 10'd700;
    tick(); tick();
    @(negedge clk); local_sel = 1'b1;
    @(posedge clk); #1;
    check("sel_deferred", 32'(output_pos), 32'(mout));
    tick();

    // Stretched tick gives one update
    @(negedge clk); frame_tick = 1'b1;
    @(posedge clk); #1;
    model_tick();
    check_all(1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_all(1'b0);
    end
    @(negedge clk); frame_tick = 1'b0;

    // Reset mid-travel with a coincident tick
    set_mode(1'b0, 1'b1, 1'b0);
    mouse_ypos = 12'd0;
    tick(); tick();
    do_reset(1'b1);
    check("rst_mid_travel", 32'(paddle(0)), 32'd336);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      @(negedge clk);
      screen_idle   = ($urandom_range(0, 7) == 0);
      screen_single = ($urandom_range(0, 2) == 0);
      screen_multi  = ($urandom_range(0, 1) == 0);
      mouse_ypos    = 12'($urandom_range(0, 4095));
      remote_ypos   = 10'($urandom_range(0, 1023));
      ball_ypos     = 12'($urandom_range(0, 4095));
      local_sel     = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
